// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB bus bundle between a requester and apb_slave_mem.
interface apb_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer backed by a word array, with wait states,
// address errors, byte-strobed writes and a sticky protocol-violation flag.
module apb_slave_mem #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    apb_slave_mem_if.slave       bus,
    input  logic [3:0]           wait_cfg,
    output logic                 prot_err
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LSB     = $clog2(STRB_W);
    localparam int ADDR_W1 = ADDR_W + 1;
    localparam logic [ADDR_W:0]   SPAN      = ADDR_W1'(DEPTH * STRB_W);
    localparam logic [ADDR_W-1:0] ALIGN_MSK = ADDR_W'(STRB_W - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_strb;
    logic [3:0]          r_cnt;
    logic                r_pready;
    logic                r_pslverr;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_prot_err;

    logic                w_setup;
    logic                w_complete;
    logic                w_abort;
    logic                w_tick;
    logic                w_viol;
    logic                w_mismatch;
    logic                w_in_hit;
    logic [IDX_W-1:0]    w_in_idx;
    logic                w_lat_hit;
    logic [IDX_W-1:0]    w_lat_idx;

    function automatic logic f_hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a >= BASE_ADDR) && (off < SPAN) && ((a & ALIGN_MSK) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LSB);
    endfunction

    assign w_in_hit  = f_hit(bus.paddr);
    assign w_in_idx  = f_idx(bus.paddr);
    assign w_lat_hit = f_hit(r_addr);
    assign w_lat_idx = f_idx(r_addr);

    // The requester must hold the whole request stable until the transfer completes.
    assign w_mismatch = (bus.paddr != r_addr) || (bus.pwrite != r_write) ||
                        (bus.pwdata != r_wdata) || (bus.pstrb != r_strb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_setup      = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        w_tick       = 1'b0;
        w_viol       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.psel) begin
                    if (!bus.penable) begin
                        w_setup      = 1'b1;
                        w_next_state = ST_ACCESS;
                    end else begin
                        w_viol = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (!bus.psel || !bus.penable || w_mismatch) begin
                    w_viol       = 1'b1;
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_pready) begin
                    w_complete   = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_tick = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_cnt      <= 4'd0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
            r_prot_err <= 1'b0;
        end else begin
            if (w_viol) begin
                r_prot_err <= 1'b1;
            end

            if (w_setup) begin
                r_addr    <= bus.paddr;
                r_write   <= bus.pwrite;
                r_wdata   <= bus.pwdata;
                r_strb    <= bus.pstrb;
                r_cnt     <= wait_cfg;
                r_pready  <= (wait_cfg == 4'd0);
                r_pslverr <= (wait_cfg == 4'd0) && !w_in_hit;
                if ((wait_cfg == 4'd0) && !bus.pwrite) begin
                    r_prdata <= w_in_hit ? r_mem[w_in_idx] : '0;
                end
            end else if (w_abort) begin
                r_cnt     <= 4'd0;
                r_pready  <= 1'b0;
                r_pslverr <= 1'b0;
            end else if (w_complete) begin
                r_pready  <= 1'b0;
                r_pslverr <= 1'b0;
                if (r_write && w_lat_hit) begin
                    for (int i = 0; i < STRB_W; i++) begin
                        if (r_strb[i]) begin
                            r_mem[w_lat_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                        end
                    end
                end
            end else if (w_tick) begin
                r_cnt    <= r_cnt - 4'd1;
                r_pready <= (r_cnt == 4'd1);
                // Last wait cycle: the response becomes visible with pready.
                if (r_cnt == 4'd1) begin
                    r_pslverr <= !w_lat_hit;
                    if (!r_write) begin
                        r_prdata <= w_lat_hit ? r_mem[w_lat_idx] : '0;
                    end
                end
            end
        end
    end

    assign bus.prdata  = r_prdata;
    assign bus.pready  = r_pready;
    assign bus.pslverr = r_pslverr;
    assign prot_err    = r_prot_err;
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed self-checking bench for apb_slave_mem.
module tb_apb_slave_mem;
    localparam logic [31:0] BASE = 32'h0000_4000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] wait_cfg = 4'd0;
    logic       prot_err;
    int         errors = 0;
    int         checks = 0;

    apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_slave_mem #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(64), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .wait_cfg(wait_cfg), .prot_err(prot_err)
    );

    always #5 clk = ~clk;

    task automatic xfer(input logic wr, input logic [31:0] off, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] wc,
                        output logic [31:0] rd, output logic err, output int cyc);
        int n;
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = BASE + off; bus.pwdata = data; bus.pstrb = strb; wait_cfg = wc;
        @(posedge clk);
        @(negedge clk);
        bus.penable = 1'b1;
        wait_cfg = ~wc;
        cyc = 2; n = 0;
        while (bus.pready !== 1'b1 && n < 40) begin
            @(posedge clk); @(negedge clk);
            cyc++; n++;
        end
        rd = bus.prdata; err = bus.pslverr;
        if (bus.pready !== 1'b1) cyc = -1;
        @(posedge clk);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL reset_pready got=%b exp=0", bus.pready); end
        checks++; if (bus.pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got=%b exp=0", bus.pslverr); end
        checks++; if (bus.prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata got=%h exp=0", bus.prdata); end
        checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL reset_prot_err got=%b exp=0", prot_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic err; int cyc;
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 4'd0, rd, err, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL basic_wr_cycles got=%0d exp=2", cyc); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_wr_err got=%b exp=0", err); end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, err, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL basic_rd_cycles got=%0d exp=2", cyc); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_rd_err got=%b exp=0", err); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); end
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int cyc;
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 4'd3, rd, err, cyc);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL wait_cycles got=%0d exp=5", cyc); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wait_rd_data got=%h exp=0", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wait_rd_err got=%b exp=0", err); end
        bus_idle();
        checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL wait_pready_one_cycle got=%b exp=0", bus.pready); end
        checks++; if (bus.prdata !== 32'h0) begin errors++; $display("FAIL wait_prdata_hold got=%h exp=0", bus.prdata); end
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic err; int cyc;
        xfer(1'b1, 32'h08, 32'h1122_3344, 4'hF, 4'd1, rd, err, cyc);
        xfer(1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, 4'd2, rd, err, cyc);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 4'd0, rd, err, cyc);
        checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_rd_data got=%h exp=11bb33dd", rd); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL strobe_rd_cycles got=%0d exp=2", cyc); end
        bus_idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int cyc;
        xfer(1'b1, 32'h00, 32'h5A5A_0001, 4'hF, 4'd0, rd, err, cyc);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_good_wr got=%b exp=0", err); end
        xfer(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 4'd0, rd, err, cyc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_wr_range got=%b exp=1", err); end
        xfer(1'b1, 32'h02, 32'hFFFF_FFFF, 4'hF, 4'd2, rd, err, cyc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_wr_misaligned got=%b exp=1", err); end
        xfer(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 4'd0, rd, err, cyc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_wr_below_base got=%b exp=1", err); end
        xfer(1'b0, 32'h00, 32'h0, 4'h0, 4'd0, rd, err, cyc);
        checks++; if (rd !== 32'h5A5A_0001) begin errors++; $display("FAIL err_word0_intact got=%h exp=5a5a0001", rd); end
        xfer(1'b0, 32'h100, 32'h0, 4'h0, 4'd1, rd, err, cyc);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rd_range_data got=%h exp=0", rd); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_rd_range_err got=%b exp=1", err); end
        xfer(1'b0, 32'hFC, 32'h0, 4'h0, 4'd0, rd, err, cyc);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_last_word_hit got=%b exp=0", err); end
        bus_idle();
        checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL err_no_prot got=%b exp=0", prot_err); end
    endtask

    task automatic test_protocol();
        logic [31:0] rd; logic err; int cyc; int saw_ready;
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0; bus.paddr = BASE;
        bus_idle();
        checks++; if (prot_err !== 1'b1) begin errors++; $display("FAIL prot_no_setup got=%b exp=1", prot_err); end
        do_reset();
        checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL prot_cleared got=%b exp=0", prot_err); end
        xfer(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 4'd0, rd, err, cyc);
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = BASE + 32'h20; bus.pwdata = 32'h1234_5678; bus.pstrb = 4'hF; wait_cfg = 4'd4;
        @(posedge clk);
        @(negedge clk);
        bus.penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.paddr = BASE + 32'h24;
        saw_ready = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.pready === 1'b1) saw_ready++;
        end
        bus_idle();
        checks++; if (saw_ready !== 0) begin errors++; $display("FAIL prot_abort_pready got=%0d exp=0", saw_ready); end
        checks++; if (prot_err !== 1'b1) begin errors++; $display("FAIL prot_addr_change got=%b exp=1", prot_err); end
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 4'd0, rd, err, cyc);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL prot_word20_intact got=%h exp=cafef00d", rd); end
        xfer(1'b0, 32'h24, 32'h0, 4'h0, 4'd0, rd, err, cyc);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL prot_word24_intact got=%h exp=0", rd); end
        bus_idle();
        checks++; if (prot_err !== 1'b1) begin errors++; $display("FAIL prot_sticky got=%b exp=1", prot_err); end
        do_reset();
        checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL prot_reset_clear got=%b exp=0", prot_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sb [8];
        logic [31:0] rd; logic err; int cyc; logic [3:0] wc;
        for (int i = 0; i < 8; i++) begin
            sb[i] = $urandom | 32'h1;
            wc = 4'($urandom_range(0, 15));
            xfer(1'b1, 32'h40 + 32'(4 * i), sb[i], 4'hF, wc, rd, err, cyc);
            checks++; if (cyc !== 2 + int'(wc) || err !== 1'b0) begin errors++; $display("FAIL b2b_wr%0d cycles=%0d err=%b exp cycles=%0d err=0", i, cyc, err, 2 + int'(wc)); end
        end
        for (int i = 0; i < 8; i++) begin
            wc = 4'($urandom_range(0, 15));
            xfer(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, wc, rd, err, cyc);
            checks++; if (rd !== sb[i] || cyc !== 2 + int'(wc)) begin errors++; $display("FAIL b2b_rd%0d data=%h cycles=%0d exp data=%h cycles=%0d", i, rd, cyc, sb[i], 2 + int'(wc)); end
        end
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = BASE + 32'h40; bus.pwdata = 32'hFFFF_FFFF; bus.pstrb = 4'hF; wait_cfg = 4'd10;
        @(posedge clk);
        @(negedge clk);
        bus.penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.prdata !== sb[7]) begin errors++; $display("FAIL b2b_prdata_before_reset got=%h exp=%h", bus.prdata, sb[7]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.prdata !== 32'h0 || bus.pready !== 1'b0 || bus.pslverr !== 1'b0) begin errors++; $display("FAIL b2b_async_reset prdata=%h pready=%b pslverr=%b exp 0 0 0", bus.prdata, bus.pready, bus.pslverr); end
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wc = 4'($urandom_range(0, 15));
            xfer(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, wc, rd, err, cyc);
            checks++; if (rd !== 32'h0 || cyc !== 2 + int'(wc)) begin errors++; $display("FAIL b2b_after_reset%0d data=%h cycles=%0d exp data=0 cycles=%0d", i, rd, cyc, 2 + int'(wc)); end
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_strobes();
        test_errors();
        test_protocol();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
